mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the 4:1, 2-bit mux (mux4_1).
- Drives the mux `sel` input through a programmable set of enabled channels, waits a settle time on each, then captures the mux output.
- Presents each capture as a one-cycle valid sample and keeps a packed copy of the last value seen per channel.
- Supports a one-shot scan or continuous round-robin scanning.

Parameters:
- DW, 2: data width of mux data inputs and output.
- NCH, 4: number of mux channels. Fixed at 4; `sel` is 2 bits.
- DWELL, 2: cycles `sel` is held on a channel before capture. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a scan. Sampled only in IDLE.
- cont  input  1  continuous mode. Latched together with `start`.
- stop  input  1  abort the scan. Honoured in any non-IDLE state.
- chan_mask  input  NCH  enabled channels. Bit i enables channel i. Latched on `start`.
- mux_out  input  DW  output of the downstream mux.
- sel  output  2  mux select; connects to mux `sel`.
- busy  output  1  high while scanning.
- sample_valid  output  1  one-cycle pulse: a sample was captured.
- sample_ch  output  2  channel of the current sample.
- sample_data  output  DW  captured `mux_out`.
- ch_data  output  NCH*DW  last captured value per channel, packed; channel i occupies bits [i*DW +: DW].
- done  output  1  one-cycle pulse: a one-shot scan completed.

Behaviour:
- Reset: while `rst` is high, all of the following hold 0, asynchronously: state=IDLE, `sel`, `busy`, `sample_valid`, `sample_ch`, `sample_data`, `ch_data`, `done`, dwell counter, latched mask, latched `cont`.
- Reset mid-scan: aborts immediately, no `done`. After `rst` falls, the next `start` is required.
- FSM states: IDLE, SETTLE, FIN.
- IDLE:
  - On an edge with `start`=1 and `chan_mask`≠0: latch mask and `cont`; `sel` ← lowest enabled channel; counter ← 0; `busy` ← 1; go to SETTLE.
  - On `start`=1 with `chan_mask`=0: go to FIN. No samples are produced and `busy` stays 0.
- SETTLE:
  - Each edge increments the counter.
  - On the edge where counter = DWELL−1:
    - `sample_data` ← `mux_out`, `sample_ch` ← `sel`, `ch_data[sel]` ← `mux_out`, `sample_valid` ← 1 for exactly the following cycle.
    - Next channel = lowest enabled channel with index > `sel`.
    - If a next channel exists: `sel` ← it; counter ← 0; stay in SETTLE.
    - If none and `cont`=1: wrap; `sel` ← lowest enabled channel; counter ← 0.
    - If none and `cont`=0: go to FIN; `busy` ← 0.
- FIN: `done`=1 for one cycle, then IDLE. In the one-shot case `done` is coincident with the final `sample_valid`.
- Timing: `sel` changes only on capture edges or on entry from IDLE. Each channel costs exactly DWELL cycles. The first `sample_valid` appears DWELL cycles after the `start` edge.
- `stop`:
  - Next edge returns to IDLE with `busy`=0 and no `done`.
  - If `stop` coincides with a capture edge, the capture still occurs (`sample_valid` pulses); the transition to IDLE takes priority.
  - `sel` and `ch_data` hold their last values after a stop.
- `start` while `busy`: ignored. Mask/`cont` changes while busy: ignored until the next `start`.
- Single-channel mask with `cont`=1: that channel is resampled every DWELL cycles and `sel` stays constant.
- `mux_out` is treated as combinational from `sel`. The settle requirement is met by DWELL ≥ 1.

Decomposition:
- Shared include header holds:
  - state encodings (IDLE=2'd0, SETTLE=2'd1, FIN=2'd2);
  - the NCH and DW defaults;
  - the width of the DWELL counter (4 bits).
- Natural sub-module: `next_chan_pick`, a combinational priority finder. Inputs: mask and current `sel`. Outputs: next index above `sel`, lowest index, and a `found` flag.
- Top level instantiates `mux_scan_ctrl` feeding `mux4_1`.

Test Plan:
Common setup: DWELL=2 with a `mux4_1` instance where d0=0, d1=1, d2=2, d3=3, so `mux_out` equals `sel`.
1. Full one-shot scan: `chan_mask`=4'b1111, `cont`=0, `start` pulse → `sample_valid` 2, 4, 6 and 8 cycles after start with (ch, data) = (0,0), (1,1), (2,2), (3,3). `done` coincides with the 4th sample; `ch_data`=8'b11_10_01_00; `busy` falls with `done`.
2. Sparse mask: `chan_mask`=4'b1010 → `sel` sequence 1 then 3. Samples are (1,1) at +2 and (3,3) at +4, with `done` at +4. `ch_data` fields 0 and 2 stay 0.
3. Continuous mode and stop: `chan_mask`=4'b0001, `cont`=1 → `sample_valid` every 2 cycles with (0,0) and `sel` constant 0. Asserting `stop` for one cycle → IDLE, `busy`=0, no `done`.
4. Empty mask: `chan_mask`=0, `start` → `done` pulse the next cycle; `busy` and `sample_valid` never assert.
5. Start while busy and async reset: a second `start` at +3 of scan 1 is ignored and the sequence is unchanged. Asserting `rst` at +5 clears all outputs before the next edge, with no `done`.
6. DWELL=1 with mask 4'b1111 → samples on 4 consecutive cycles with `sel` advancing every cycle.

Source files
------------

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and defaults for the mux scan sequencer.
// State encoding, default widths and dwell counter width.
package mux_scan_ctrl_pkg;

  localparam int DW_DEF  = 2;
  localparam int NCH_DEF = 4;
  localparam int CNT_W   = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_FIN    = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_ctrl_next_chan_pick.sv
// Combinational priority finder over the channel mask.
// Ports: mask_i, cur_i -> next_o (lowest > cur), low_o, found_o.
module next_chan_pick
  import mux_scan_ctrl_pkg::*;
#(
  parameter int NCH = NCH_DEF
) (
  input  logic [NCH-1:0]   mask_i,
  input  logic [SEL_W-1:0] cur_i,
  output logic [SEL_W-1:0] next_o,
  output logic [SEL_W-1:0] low_o,
  output logic             found_o
);

  // Descending walk so the last hit is the lowest index.
  always_comb begin
    next_o  = '0;
    low_o   = '0;
    found_o = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        low_o = SEL_W'(i);
      end
      if (mask_i[i] && (i > int'(cur_i))) begin
        next_o  = SEL_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer driving a 4:1 mux select and capturing its output.
// Ports: start/cont/stop/chan_mask/mux_out in; sel, busy, samples, done out.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int DWELL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              stop,
  input  logic [NCH-1:0]    chan_mask,
  input  logic [DW-1:0]     mux_out,
  output logic [1:0]        sel,
  output logic              busy,
  output logic              sample_valid,
  output logic [1:0]        sample_ch,
  output logic [DW-1:0]     sample_data,
  output logic [NCH*DW-1:0] ch_data,
  output logic              done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                sv_q, sv_d;
  logic [SEL_W-1:0]    sch_q, sch_d;
  logic [DW-1:0]       sdat_q, sdat_d;
  logic [NCH*DW-1:0]   chd_q, chd_d;
  logic [NCH-1:0]      mask_q, mask_d;
  logic                cont_q, cont_d;

  logic [NCH-1:0]      pick_mask;
  logic [SEL_W-1:0]    nxt, low;
  logic                found;

  // In IDLE the first channel comes from the live mask.
  assign pick_mask = (state_q == ST_IDLE) ? chan_mask : mask_q;

  next_chan_pick #(
    .NCH (NCH)
  ) u_pick (
    .mask_i  (pick_mask),
    .cur_i   (sel_q),
    .next_o  (nxt),
    .low_o   (low),
    .found_o (found)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    sv_d    = 1'b0;
    sch_d   = sch_q;
    sdat_d  = sdat_q;
    chd_d   = chd_q;
    mask_d  = mask_q;
    cont_d  = cont_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (|chan_mask) begin
            mask_d  = chan_mask;
            cont_d  = cont;
            sel_d   = low;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sv_d   = 1'b1;
          sch_d  = sel_q;
          sdat_d = mux_out;
          chd_d[int'(sel_q)*DW +: DW] = mux_out;
          cnt_d  = '0;
          // A stop on the capture edge keeps sel on this channel.
          if (!stop) begin
            if (found) begin
              sel_d = nxt;
            end else if (cont_q) begin
              sel_d = low;
            end else begin
              state_d = ST_FIN;
              busy_d  = 1'b0;
            end
          end
        end
        if (stop) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      sv_q    <= 1'b0;
      sch_q   <= '0;
      sdat_q  <= '0;
      chd_q   <= '0;
      mask_q  <= '0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      sv_q    <= sv_d;
      sch_q   <= sch_d;
      sdat_q  <= sdat_d;
      chd_q   <= chd_d;
      mask_q  <= mask_d;
      cont_q  <= cont_d;
    end
  end

  assign sel          = sel_q;
  assign busy         = busy_q;
  assign sample_valid = sv_q;
  assign sample_ch    = sch_q;
  assign sample_data  = sdat_q;
  assign ch_data      = chd_q;
  assign done         = (state_q == ST_FIN);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl with a behavioural mux and scan model.
// Two instances: DWELL=2 (main) and DWELL=1.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cont, stop;
  logic [3:0] chan_mask;
  logic [1:0] dv [4];

  logic [1:0] mo0, sel0, sch0, sdat0;
  logic       busy0, sv0, done0;
  logic [7:0] chd0;
  logic [1:0] mo1, sel1, sch1, sdat1;
  logic       busy1, sv1, done1;
  logic [7:0] chd1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign mo0 = dv[sel0];
  assign mo1 = dv[sel1];

  mux_scan_ctrl #(.DW(2), .NCH(4), .DWELL(2)) u0 (
    .clk(clk), .rst(rst), .start(start), .cont(cont),
    .stop(stop), .chan_mask(chan_mask), .mux_out(mo0),
    .sel(sel0), .busy(busy0), .sample_valid(sv0),
    .sample_ch(sch0), .sample_data(sdat0),
    .ch_data(chd0), .done(done0)
  );

  mux_scan_ctrl #(.DW(2), .NCH(4), .DWELL(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .cont(cont),
    .stop(stop), .chan_mask(chan_mask), .mux_out(mo1),
    .sel(sel1), .busy(busy1), .sample_valid(sv1),
    .sample_ch(sch1), .sample_data(sdat1),
    .ch_data(chd1), .done(done1)
  );

  typedef struct {
    bit sv;
    bit busy;
    bit done;
    bit selv;
    int ch;
    int sel;
  } exp_t;

  logic [1:0] exp_sel, exp_sch, exp_sdat;
  logic [1:0] exp_chd [4];

  // Expected outputs k cycles after the start edge, from the
  // ordered list of enabled channels.
  function automatic exp_t model(logic [3:0] m, bit c,
                                 int d, int k);
    exp_t e;
    int lst[$];
    int l;
    int j;
    e = '{default: 0};
    for (int i = 0; i < 4; i++)
      if (m[i]) lst.push_back(i);
    l = lst.size();
    if (l == 0) begin
      e.done = (k == 0);
      return e;
    end
    e.selv = 1;
    j = k / d;
    if (c) begin
      e.busy = 1;
      e.sel  = lst[j % l];
    end else begin
      e.busy = (k < l * d);
      e.done = (k == l * d);
      e.sel  = lst[(j < l) ? j : l - 1];
    end
    if (k > 0 && k % d == 0 && (c || j <= l)) begin
      e.sv = 1;
      e.ch = lst[(j - 1) % l];
    end
    return e;
  endfunction

  task automatic model_step(input exp_t e);
    if (e.selv) exp_sel = 2'(e.sel);
    if (e.sv) begin
      exp_sch = 2'(e.ch);
      exp_sdat = dv[e.ch];
      exp_chd[e.ch] = dv[e.ch];
    end
  endtask

  function automatic logic [16:0] expv(exp_t e);
    return {e.sv, e.busy, e.done, exp_sel, exp_sch,
            exp_sdat, exp_chd[3], exp_chd[2],
            exp_chd[1], exp_chd[0]};
  endfunction

  function automatic logic [16:0] pack0();
    return {sv0, busy0, done0, sel0, sch0, sdat0, chd0};
  endfunction

  function automatic logic [16:0] pack1();
    return {sv1, busy1, done1, sel1, sch1, sdat1, chd1};
  endfunction

  task automatic clear_exp();
    exp_sel = '0;
    exp_sch = '0;
    exp_sdat = '0;
    for (int i = 0; i < 4; i++) exp_chd[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0;
    stop = 0;
    cont = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    clear_exp();
  endtask

  task automatic test_reset();
    exp_t z;
    z = '{default: 0};
    @(negedge clk);
    clear_exp();
    n_tests++;
    if (pack0() !== expv(z)) begin
      n_fail++;
      $display("FAIL reset0 got %h exp %h", pack0(), expv(z));
    end
    n_tests++;
    if (pack1() !== expv(z)) begin
      n_fail++;
      $display("FAIL reset1 got %h exp %h", pack1(), expv(z));
    end
    rst = 0;
  endtask

  task automatic test_full_scan();
    exp_t e;
    for (int i = 0; i < 4; i++) dv[i] = 2'(i);
    @(negedge clk);
    chan_mask = 4'b1111;
    cont = 0;
    start = 1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 0;
        chan_mask = 4'($urandom);
        cont = 1'($urandom);
      end
      e = model(4'b1111, 0, 2, k);
      model_step(e);
      n_tests++;
      if (pack0() !== expv(e)) begin
        n_fail++;
        $display("FAIL full k=%0d got %h exp %h",
                 k, pack0(), expv(e));
      end
    end
  endtask

  task automatic test_sparse();
    exp_t e;
    do_reset();
    @(negedge clk);
    chan_mask = 4'b1010;
    cont = 0;
    start = 1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k == 0) start = 0;
      e = model(4'b1010, 0, 2, k);
      model_step(e);
      n_tests++;
      if (pack0() !== expv(e)) begin
        n_fail++;
        $display("FAIL sparse k=%0d got %h exp %h",
                 k, pack0(), expv(e));
      end
    end
  endtask

  task automatic test_cont_stop();
    exp_t e;
    @(negedge clk);
    chan_mask = 4'b0001;
    cont = 1;
    start = 1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k == 0) start = 0;
      e = model(4'b0001, 1, 2, k);
      model_step(e);
      n_tests++;
      if (pack0() !== expv(e)) begin
        n_fail++;
        $display("FAIL cont k=%0d got %h exp %h",
                 k, pack0(), expv(e));
      end
    end
    // Stop lands on a capture edge: sample still taken.
    stop = 1;
    @(negedge clk);
    stop = 0;
    e = model(4'b0001, 1, 2, 8);
    e.busy = 0;
    model_step(e);
    n_tests++;
    if (pack0() !== expv(e)) begin
      n_fail++;
      $display("FAIL stop_cap got %h exp %h",
               pack0(), expv(e));
    end
    e = '{default: 0};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (pack0() !== expv(e)) begin
        n_fail++;
        $display("FAIL stop_idle k=%0d got %h exp %h",
                 k, pack0(), expv(e));
      end
    end
  endtask

  task automatic test_empty();
    exp_t e;
    @(negedge clk);
    chan_mask = 4'b0000;
    cont = 0;
    start = 1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 0) start = 0;
      e = model(4'b0000, 0, 2, k);
      model_step(e);
      n_tests++;
      if (pack0() !== expv(e)) begin
        n_fail++;
        $display("FAIL empty k=%0d got %h exp %h",
                 k, pack0(), expv(e));
      end
    end
  endtask

  task automatic test_busy_reset();
    exp_t e;
    @(negedge clk);
    chan_mask = 4'b1111;
    cont = 0;
    start = 1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) start = 0;
      if (k == 3) start = 0;
      e = model(4'b1111, 0, 2, k);
      model_step(e);
      n_tests++;
      if (pack0() !== expv(e)) begin
        n_fail++;
        $display("FAIL busy_start k=%0d got %h exp %h",
                 k, pack0(), expv(e));
      end
      if (k == 2) begin
        start = 1;
        chan_mask = 4'b0001;
        cont = 1;
      end
    end
    #1 rst = 1;
    #1;
    clear_exp();
    e = '{default: 0};
    n_tests++;
    if (pack0() !== expv(e)) begin
      n_fail++;
      $display("FAIL async_rst got %h exp %h",
               pack0(), expv(e));
    end
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (pack0() !== expv(e)) begin
        n_fail++;
        $display("FAIL post_rst k=%0d got %h exp %h",
                 k, pack0(), expv(e));
      end
    end
  endtask

  task automatic test_dwell1();
    exp_t e;
    do_reset();
    @(negedge clk);
    chan_mask = 4'b1111;
    cont = 0;
    start = 1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k == 0) start = 0;
      e = model(4'b1111, 0, 1, k);
      model_step(e);
      n_tests++;
      if (pack1() !== expv(e)) begin
        n_fail++;
        $display("FAIL dwell1 k=%0d got %h exp %h",
                 k, pack1(), expv(e));
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic [3:0] m;
    int l;
    do_reset();
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 4; i++) dv[i] = 2'($urandom);
      m = 4'($urandom);
      l = $countones(m);
      @(negedge clk);
      chan_mask = m;
      cont = 0;
      start = 1;
      for (int k = 0; k <= l * 2 + 2; k++) begin
        @(negedge clk);
        if (k == 0) begin
          start = 0;
          chan_mask = 4'($urandom);
        end
        e = model(m, 0, 2, k);
        model_step(e);
        n_tests++;
        if (pack0() !== expv(e)) begin
          n_fail++;
          $display("FAIL rand it=%0d m=%b k=%0d got %h exp %h",
                   it, m, k, pack0(), expv(e));
        end
      end
    end
  endtask

  initial begin
    rst = 1;
    start = 0;
    cont = 0;
    stop = 0;
    chan_mask = '0;
    for (int i = 0; i < 4; i++) dv[i] = 2'(i);
    test_reset();
    test_full_scan();
    test_sparse();
    test_cont_stop();
    test_empty();
    test_busy_reset();
    test_dwell1();
    test_random();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
